register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 9 +
 rtl/register_file_reg16_en.sv | 20 ++
 rtl/register_file.sv | 56 +++++
 tb/tb_register_file.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared constants for the register file slice.
package register_file_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned REG_ZERO = 0;

endpackage : register_file_pkg

// File: rtl/register_file_reg16_en.sv
// Single storage register with load enable and synchronous active-low clear.
module reg16_en #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : reg16_en

// File: rtl/register_file.sv
// Two-read / one-write register file with hardwired zero register.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file #(
    parameter int unsigned DATA_W = register_file_pkg::DATA_W,
    parameter int unsigned ADDR_W = register_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    import register_file_pkg::*;

    localparam int unsigned NUM = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM];
    logic              wr_valid;

    assign wr_valid = we && (waddr != ADDR_W'(REG_ZERO));

    // Index 0 has no storage; it is a constant zero source.
    assign regs[0] = '0;

    for (genvar i = 1; i < NUM; i++) begin : g_reg
        reg16_en #(
            .WIDTH (DATA_W)
        ) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (wr_valid && (waddr == ADDR_W'(i))),
            .d     (wdata),
            .q     (regs[i])
        );
    end

    // Read mux; the port outputs feed the ALU directly with no register stage.
    always_comb begin
        rdata_a = regs[raddr_a];
        rdata_b = regs[raddr_b];
`ifdef REGFILE_BYPASS_EN
        if (rst_n && wr_valid && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
        if (rst_n && wr_valid && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
`endif
    end

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table plus random regression.
module tb_register_file;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
    localparam int unsigned NR = 8;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic          rst;
        logic          w;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr_a;
    logic [AW-1:0] raddr_b;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] model [NR];
    vec_t          vecs [$];

    register_file dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Architectural view of a read: zero register, optional forwarding, else stored value.
    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] addr, input logic r,
                                               input logic w, input logic [AW-1:0] wa,
                                               input logic [DW-1:0] wd);
        if (addr == 0) return '0;
        if (BYP && r && w && wa == addr) return wd;
        return model[addr];
    endfunction

    // Drive one cycle, check reads before the edge, then advance the model.
    task automatic step(input vec_t v, input string tag);
        rst_n   = v.rst;
        we      = v.w;
        waddr   = v.wa;
        wdata   = v.wd;
        raddr_a = v.ra;
        raddr_b = v.rb;
        @(negedge clk);
        check({tag, "_a"}, rdata_a, v.ea);
        check({tag, "_b"}, rdata_b, v.eb);
        @(posedge clk);
        if (!v.rst) begin
            for (int k = 0; k < NR; k++) model[k] = '0;
        end else if (v.w && v.wa != 0) begin
            model[v.wa] = v.wd;
        end
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic w, input int wa, input logic [DW-1:0] wd,
                                input int ra, input int rb, input logic [DW-1:0] ea,
                                input logic [DW-1:0] eb);
        vec_t v;
        v.rst = r; v.w = w; v.wa = AW'(wa); v.wd = wd;
        v.ra = AW'(ra); v.rb = AW'(rb); v.ea = ea; v.eb = eb;
        return v;
    endfunction

    initial begin
        vec_t v;

        // Reset sweep across all indices on both ports.
        for (int i = 0; i < NR; i++) vecs.push_back(mk(1, 0, 0, 16'h0, i, NR - 1 - i, 16'h0, 16'h0));
        // Write r3/r5 then read back.
        vecs.push_back(mk(1, 1, 3, 16'hA5A5, 3, 5, BYP ? 16'hA5A5 : 16'h0, 16'h0));
        vecs.push_back(mk(1, 1, 5, 16'h0F0F, 3, 5, 16'hA5A5, BYP ? 16'h0F0F : 16'h0));
        vecs.push_back(mk(1, 0, 0, 16'h0, 3, 5, 16'hA5A5, 16'h0F0F));
        // Writes to r0 are dropped, even in the same cycle.
        vecs.push_back(mk(1, 1, 0, 16'hFFFF, 0, 0, 16'h0, 16'h0));
        vecs.push_back(mk(1, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0));
        // Same-cycle hazard on r2.
        vecs.push_back(mk(1, 1, 2, 16'h1111, 1, 1, 16'h0, 16'h0));
        vecs.push_back(mk(1, 1, 2, 16'h2222, 2, 3, BYP ? 16'h2222 : 16'h1111, 16'hA5A5));
        vecs.push_back(mk(1, 0, 0, 16'h0, 2, 2, 16'h2222, 16'h2222));
        // Reset beats a concurrent write; forwarding suppressed during reset.
        vecs.push_back(mk(1, 1, 4, 16'h1234, 4, 0, BYP ? 16'h1234 : 16'h0, 16'h0));
        vecs.push_back(mk(0, 1, 4, 16'hBEEF, 4, 4, 16'h1234, 16'h1234));
        vecs.push_back(mk(1, 0, 0, 16'h0, 4, 3, 16'h0, 16'h0));
        // Normal operation resumes right after reset.
        vecs.push_back(mk(1, 1, 6, 16'h5A5A, 6, 4, BYP ? 16'h5A5A : 16'h0, 16'h0));
        vecs.push_back(mk(1, 0, 6, 16'hFFFF, 6, 6, 16'h5A5A, 16'h5A5A));
        vecs.push_back(mk(1, 0, 0, 16'h0, 6, 6, 16'h5A5A, 16'h5A5A));

        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < NR; k++) model[k] = '0;
        #1;

        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // Random regression against the array model.
        for (int n = 0; n < 10000; n++) begin
            v.rst = ($urandom_range(63) != 0);
            v.w   = ($urandom_range(3) != 0);
            v.wa  = AW'($urandom_range(NR - 1));
            v.wd  = DW'($urandom);
            v.ra  = ($urandom_range(3) == 0) ? v.wa : AW'($urandom_range(NR - 1));
            v.rb  = ($urandom_range(3) == 0) ? v.wa : AW'($urandom_range(NR - 1));
            v.ea  = exp_read(v.ra, v.rst, v.w, v.wa, v.wd);
            v.eb  = exp_read(v.rb, v.rst, v.w, v.wa, v.wd);
            step(v, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_register_file
